// File: rtl/ins_fetch_controller.sv
// rtl/ins_fetch_controller.sv - PC sequencer and one-slot fetch buffer feeding decode
// Optional halt-opcode detection is enabled with `define HALT_DETECT_EN.
module ins_fetch_controller #(
  parameter int unsigned          word_size   = 8,
  parameter int unsigned          index_size  = 4,
  parameter logic [word_size-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [index_size-1:0] prog_count,
  input  logic [word_size-1:0]  ins_val,
  output logic [word_size-1:0]  fetch_ins,
  output logic [index_size-1:0] fetch_pc,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  input  logic                  branch_en,
  input  logic [index_size-1:0] branch_target,
  output logic                  halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [index_size-1:0] prog_count_q, prog_count_d;
  logic [word_size-1:0]  fetch_ins_q, fetch_ins_d;
  logic [index_size-1:0] fetch_pc_q, fetch_pc_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  load;

  // A branch always wins: it flushes the slot and blocks any load or halt that cycle.
  assign load = (state_q == ST_FETCH) && (!fetch_valid_q || fetch_ready) && !branch_en;

  always_comb begin
    state_d       = state_q;
    prog_count_d  = prog_count_q;
    fetch_ins_d   = fetch_ins_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;

    if (branch_en) begin
      prog_count_d  = branch_target;
      fetch_valid_d = 1'b0;
    end else begin
      if (load) begin
        fetch_ins_d   = ins_val;
        fetch_pc_d    = prog_count_q;
        fetch_valid_d = 1'b1;
        prog_count_d  = prog_count_q + 1'b1;
`ifdef HALT_DETECT_EN
        if (ins_val == HALT_OPCODE) begin
          state_d = ST_HALT;
        end
`endif
      end else if (fetch_ready) begin
        fetch_valid_d = 1'b0;
      end
      if (start && (state_q != ST_FETCH)) begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prog_count_q  <= '0;
      fetch_ins_q   <= '0;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_count_q  <= prog_count_d;
      fetch_ins_q   <= fetch_ins_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign prog_count  = prog_count_q;
  assign fetch_ins   = fetch_ins_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_valid = fetch_valid_q;

`ifdef HALT_DETECT_EN
  assign halted = (state_q == ST_HALT);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halted = 1'b0;
`endif

endmodule
